// File: rtl/msg_bus_assembler.sv
// Lane-staging bus assembler: collects UNIT_NUM lanes into one word and queues frames in a FIFO.
// Optional partial-frame flush input is enabled by defining MSG_ASM_FLUSH_EN.
module msg_bus_assembler #(
    parameter int unsigned UNIT_NUM   = 5,
    parameter int unsigned UNIT_WIDTH = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                           sys_clk,
    input  logic                           rstn,
    input  logic [UNIT_NUM*UNIT_WIDTH-1:0] port_in_i,
    input  logic [UNIT_NUM-1:0]            load_en_i,
    input  logic [UNIT_NUM-1:0]            lane_clr_i,
`ifdef MSG_ASM_FLUSH_EN
    input  logic                           flush_i,
`endif
    output logic [UNIT_NUM*UNIT_WIDTH-1:0] port_out_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [UNIT_NUM-1:0]            filled_o,
    output logic                           stall_o,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_cnt_o,
    output logic                           err_o
);

    localparam int unsigned DataW = UNIT_NUM * UNIT_WIDTH;
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    logic [DataW-1:0]    stage_q, stage_d;
    logic [UNIT_NUM-1:0] filled_q, filled_d;
    logic                err_q, err_d;

    logic [DataW-1:0]    mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DataW-1:0]    head_q, head_d;

    logic [UNIT_NUM-1:0] load_eff, load_new, load_dup, carry;
    logic [DataW-1:0]    merged;
    logic                complete, flush_req, push_req, full, pop, push;

    // Effective loads: clear wins; loads onto empty lanes join the current frame.
    assign load_eff = load_en_i & ~lane_clr_i;
    assign load_new = load_eff & ~filled_q;
    assign load_dup = load_eff & filled_q;
    assign complete = &(filled_q | load_new);

`ifdef MSG_ASM_FLUSH_EN
    assign flush_req = flush_i & (|(filled_q | load_new));
`else
    assign flush_req = 1'b0;
`endif

    assign push_req = complete | flush_req;
    assign full     = (cnt_q == CntW'(DEPTH));
    assign pop      = out_valid_o & out_ready_i;
    assign push     = push_req & (~full | pop);
    assign stall_o  = push_req & full & ~pop;

    // Loads on a fully staged frame being pushed start the next frame instead of erroring.
    assign carry = (push && (load_new == '0)) ? load_dup : '0;

    always_comb begin
        merged = stage_q;
        for (int i = 0; i < int'(UNIT_NUM); i++) begin
            if (load_new[i]) begin
                merged[i*UNIT_WIDTH +: UNIT_WIDTH] = port_in_i[i*UNIT_WIDTH +: UNIT_WIDTH];
            end
        end
    end

    always_comb begin
        stage_d  = stage_q;
        filled_d = filled_q;
        err_d    = err_q | (|(load_dup & ~carry));
        for (int i = 0; i < int'(UNIT_NUM); i++) begin
            if (push) begin
                stage_d[i*UNIT_WIDTH +: UNIT_WIDTH] = '0;
                filled_d[i]                         = 1'b0;
                if (carry[i]) begin
                    stage_d[i*UNIT_WIDTH +: UNIT_WIDTH] = port_in_i[i*UNIT_WIDTH +: UNIT_WIDTH];
                    filled_d[i]                         = 1'b1;
                end
            end else if (lane_clr_i[i]) begin
                stage_d[i*UNIT_WIDTH +: UNIT_WIDTH] = '0;
                filled_d[i]                         = 1'b0;
            end else if (load_new[i]) begin
                stage_d[i*UNIT_WIDTH +: UNIT_WIDTH] = port_in_i[i*UNIT_WIDTH +: UNIT_WIDTH];
                filled_d[i]                         = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
        // Registered head: bypass the pushed word when it lands at the next read slot.
        if (cnt_d == '0) begin
            head_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = merged;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            stage_q  <= '0;
            filled_q <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            stage_q  <= stage_d;
            filled_q <= filled_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rstn && push) begin
            mem_q[wr_ptr_q] <= merged;
        end
    end

    assign port_out_o  = head_q;
    assign out_valid_o = (cnt_q != '0);
    assign filled_o    = filled_q;
    assign fifo_cnt_o  = cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_msg_bus_assembler.sv
// Directed self-checking bench for msg_bus_assembler (UNIT_NUM=5, UNIT_WIDTH=4, DEPTH=4).
module tb_msg_bus_assembler;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic [19:0] port_in;
    logic [4:0]  load_en;
    logic [4:0]  lane_clr;
    logic        flush;
    logic [19:0] port_out;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  filled;
    logic        stall;
    logic [2:0]  fifo_cnt;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    msg_bus_assembler #(
        .UNIT_NUM  (5),
        .UNIT_WIDTH(4),
        .DEPTH     (4)
    ) dut (
        .sys_clk    (sys_clk),
        .rstn       (rstn),
        .port_in_i  (port_in),
        .load_en_i  (load_en),
        .lane_clr_i (lane_clr),
`ifdef MSG_ASM_FLUSH_EN
        .flush_i    (flush),
`endif
        .port_out_o (port_out),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .filled_o   (filled),
        .stall_o    (stall),
        .fifo_cnt_o (fifo_cnt),
        .err_o      (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " port_out"}, 32'(port_out), 32'h0);
        check({tag, " valid"}, 32'(out_valid), 32'h0);
        check({tag, " filled"}, 32'(filled), 32'h0);
        check({tag, " stall"}, 32'(stall), 32'h0);
        check({tag, " cnt"}, 32'(fifo_cnt), 32'h0);
        check({tag, " err"}, 32'(err), 32'h0);
    endtask

    initial begin
        logic [19:0] heads [4];
        rstn      = 1'b0;
        port_in   = '0;
        load_en   = '0;
        lane_clr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rstn = 1'b1;

        // Lanes loaded one per cycle
        for (int i = 0; i < 5; i++) begin
            port_in = 20'(i + 1) << (4 * i);
            load_en = 5'(1 << i);
            tick();
            if (i < 4) check("seq filled", 32'(filled), 32'((1 << (i + 1)) - 1));
        end
        load_en = '0;
        check("seq valid", 32'(out_valid), 32'h1);
        check("seq word", 32'(port_out), 32'h54321);
        check("seq filled0", 32'(filled), 32'h0);
        check("seq cnt", 32'(fifo_cnt), 32'h1);
        out_ready = 1'b1;
        tick();
        check("seq drain cnt", 32'(fifo_cnt), 32'h0);
        check("seq drain word", 32'(port_out), 32'h0);

        // Full-rate streaming
        load_en = 5'h1F;
        for (int k = 0; k < 8; k++) begin
            port_in = 20'h11111 * 20'(k + 1);
            #1;
            check("stream stall", 32'(stall), 32'h0);
            tick();
            check("stream word", 32'(port_out), 32'h11111 * (k + 1));
            check("stream cnt", 32'(fifo_cnt), 32'h1);
        end
        load_en = '0;
        tick();
        check("stream drain", 32'(fifo_cnt), 32'h0);

        // Fill FIFO, hold the fifth frame
        out_ready = 1'b0;
        load_en   = 5'h1F;
        for (int f = 0; f < 4; f++) begin
            port_in = 20'h11111 * 20'(f + 1);
            tick();
        end
        check("full cnt", 32'(fifo_cnt), 32'h4);
        port_in = 20'h55555;
        #1;
        check("full stall comb", 32'(stall), 32'h1);
        tick();
        load_en = '0;
        #1;
        check("held stall", 32'(stall), 32'h1);
        check("held filled", 32'(filled), 32'h1F);
        check("held cnt", 32'(fifo_cnt), 32'h4);
        check("held head", 32'(port_out), 32'h11111);
        // Pop releases the held frame; lane 0 load starts the next frame
        out_ready = 1'b1;
        port_in   = 20'h6;
        load_en   = 5'h01;
        #1;
        check("pop stall", 32'(stall), 32'h0);
        tick();
        out_ready = 1'b0;
        load_en   = '0;
        #1;
        check("swap cnt", 32'(fifo_cnt), 32'h4);
        check("swap head", 32'(port_out), 32'h22222);
        check("swap stall", 32'(stall), 32'h0);
        check("carry filled", 32'(filled), 32'h01);
        check("carry err", 32'(err), 32'h0);
        heads[0] = 20'h33333;
        heads[1] = 20'h44444;
        heads[2] = 20'h55555;
        heads[3] = 20'h00000;
        out_ready = 1'b1;
        lane_clr  = 5'h1F;
        for (int j = 0; j < 4; j++) begin
            tick();
            lane_clr = '0;
            check("drain head", 32'(port_out), 32'(heads[j]));
            check("drain cnt", 32'(fifo_cnt), 32'(3 - j));
        end
        check("clr filled", 32'(filled), 32'h0);

        // Duplicate load sets sticky error and keeps first value
        out_ready = 1'b0;
        port_in   = 20'h00700;
        load_en   = 5'b00100;
        tick();
        check("dup err0", 32'(err), 32'h0);
        port_in = 20'h00900;
        tick();
        check("dup err1", 32'(err), 32'h1);
        check("dup filled", 32'(filled), 32'h04);
        port_in = 20'h54021;
        load_en = 5'b11011;
        tick();
        check("dup word", 32'(port_out), 32'h54721);
        check("dup cnt", 32'(fifo_cnt), 32'h1);
        port_in = 20'h00900;
        load_en = 5'b00100;
        tick();
        load_en  = '0;
        lane_clr = 5'b00100;
        tick();
        lane_clr = '0;
        check("lclr filled", 32'(filled), 32'h0);
        port_in = 20'h54C21;
        load_en = 5'h1F;
        tick();
        load_en = '0;
        check("reload cnt", 32'(fifo_cnt), 32'h2);
        check("err sticky", 32'(err), 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("reload word", 32'(port_out), 32'h54C21);

        // Reset mid-frame with FIFO entries
        port_in = 20'h11111;
        load_en = 5'h1F;
        tick();
        check("pre-rst cnt", 32'(fifo_cnt), 32'h2);
        port_in = 20'h00333;
        load_en = 5'b00111;
        tick();
        check("pre-rst filled", 32'(filled), 32'h07);
        rstn    = 1'b0;
        load_en = 5'h1F;
        tick();
        check_all_zero("midrst");
        rstn    = 1'b1;
        port_in = 20'hABCDE;
        tick();
        load_en = '0;
        check("post-rst word", 32'(port_out), 32'hABCDE);
        check("post-rst cnt", 32'(fifo_cnt), 32'h1);
        check("post-rst filled", 32'(filled), 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post-rst drain", 32'(fifo_cnt), 32'h0);

`ifdef MSG_ASM_FLUSH_EN
        port_in = 20'h000BA;
        load_en = 5'b00011;
        tick();
        load_en = '0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        check("flush word", 32'(port_out), 32'h000BA);
        check("flush filled", 32'(filled), 32'h0);
        check("flush cnt", 32'(fifo_cnt), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
